// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
//   mm_state_e : controller states
//   SEL_*      : matrix-select codes driven on sel
//   sat_clamp  : clamp a wide signed value to a signed w-bit range
package mm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DIM0,
    DIM1,
    DIM2,
    RD_C,
    RD_A,
    RD_B,
    WR,
    FIN
  } mm_state_e;

  localparam logic [1:0] SEL_DIM = 2'b00;
  localparam logic [1:0] SEL_A   = 2'b01;
  localparam logic [1:0] SEL_B   = 2'b10;
  localparam logic [1:0] SEL_C   = 2'b11;

  // Widest value sat_clamp can handle; callers sign-extend into this width.
  localparam int unsigned MAX_W = 128;

  // Returns v limited to [-2^(w-1), 2^(w-1)-1]; the caller keeps the low w bits.
  function automatic logic signed [MAX_W-1:0] sat_clamp(
    input logic signed [MAX_W-1:0] v,
    input int unsigned             w
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Signed multiply-accumulate for one C element.
//   clear   : acc <= 0 (highest priority)
//   load    : acc <= sext(din)            (old C value in accumulate mode)
//   latch_a : a   <= din                  (A operand)
//   mac_en  : acc <= acc + sext(a)*sext(din)
//   result  : final OUT_W value of (acc + a*din), saturated or wrapped;
//             used by the controller when the last B operand arrives.
module mm_mac
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned OUT_W  = 40,
  parameter int unsigned ACC_W  = 61,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              latch_a,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  result
);

  logic signed [DATA_W-1:0]   a_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [MAX_W-1:0]    acc_wide;
  logic signed [MAX_W-1:0]    clamped;

  always_comb begin
    prod     = a_q * $signed(din);
    acc_next = acc_q + ACC_W'(prod);
    acc_wide = MAX_W'(acc_next);
    clamped  = sat_clamp(acc_wide, OUT_W);
    result   = SAT_EN ? clamped[OUT_W-1:0] : acc_next[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      acc_q <= '0;
    end else begin
      if (latch_a) a_q <= $signed(din);
      if (clear)       acc_q <= '0;
      else if (load)   acc_q <= ACC_W'($signed(din));
      else if (mac_en) acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/mm_engine_param.sv
// Signed matrix-multiply engine: C[MxN] = A[MxK]*B[KxN] (or C += A*B).
// Reads dims, then walks C row-major, one RAM read per cycle, one write per
// element.
//   clk, reset          : clock, async active-high reset
//   start, acc_mode     : job launch (IDLE only) and accumulate select
//   busy, done, err_dim : job status
//   i, j, sel           : registered RAM address / matrix select
//   read, write         : registered RAM strobes
//   read_data           : combinational RAM read data
//   write_data          : C element, valid while write = 1
module mm_engine_param
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned IDX_W  = 20,
  parameter int unsigned OUT_W  = 40,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_mode,
  output logic              busy,
  output logic              done,
  output logic              err_dim,
  output logic [IDX_W-1:0]  i,
  output logic [IDX_W-1:0]  j,
  output logic [1:0]        sel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] read_data,
  output logic [OUT_W-1:0]  write_data
);

  // The sum is kept exact (product width + K growth + sign) so that the
  // saturate/wrap decision is made once, on the true final value.
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned BASE_W = (PROD_W > OUT_W) ? PROD_W : OUT_W;
  localparam int unsigned ACC_W  = BASE_W + IDX_W + 1;

  mm_state_e state_q, state_d;

  logic [IDX_W-1:0] m_q, k_q, n_q, m_d, k_d, n_d;
  logic [IDX_W-1:0] row_q, col_q, kk_q, row_d, col_d, kk_d;
  logic             acc_mode_q, acc_mode_d;
  logic             busy_d, done_d, err_d, read_d, write_d;
  logic [IDX_W-1:0] i_d, j_d;
  logic [1:0]       sel_d;
  logic [OUT_W-1:0] wdata_d;

  logic             mac_clear, mac_load, mac_latch, mac_en;
  logic [OUT_W-1:0] mac_result;
  logic [IDX_W-1:0] dim_in;

  assign dim_in = read_data[IDX_W-1:0];

  mm_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (mac_clear),
    .load    (mac_load),
    .latch_a (mac_latch),
    .mac_en  (mac_en),
    .din     (read_data),
    .result  (mac_result)
  );

  // Next state plus next register values; the RAM-facing outputs are then
  // derived from the *next* state so they are valid during that state.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    k_d        = k_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    kk_d       = kk_q;
    acc_mode_d = acc_mode_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err_dim;
    wdata_d    = write_data;
    i_d        = '0;
    j_d        = '0;
    sel_d      = SEL_DIM;
    read_d     = 1'b0;
    write_d    = 1'b0;
    mac_clear  = 1'b0;
    mac_load   = 1'b0;
    mac_latch  = 1'b0;
    mac_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DIM0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          acc_mode_d = acc_mode;
          row_d      = '0;
          col_d      = '0;
          kk_d       = '0;
          mac_clear  = 1'b1;
        end
      end
      DIM0: begin
        m_d     = dim_in;
        state_d = DIM1;
      end
      DIM1: begin
        k_d     = dim_in;
        state_d = DIM2;
      end
      DIM2: begin
        n_d = dim_in;
        if (m_q == '0 || k_q == '0 || dim_in == '0) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else begin
          state_d = acc_mode_q ? RD_C : RD_A;
        end
      end
      RD_C: begin
        mac_load = 1'b1;
        state_d  = RD_A;
      end
      RD_A: begin
        mac_latch = 1'b1;
        state_d   = RD_B;
      end
      RD_B: begin
        mac_en = 1'b1;
        if (kk_q == k_q - IDX_W'(1)) begin
          kk_d    = '0;
          wdata_d = mac_result;
          state_d = WR;
        end else begin
          kk_d    = kk_q + IDX_W'(1);
          state_d = RD_A;
        end
      end
      WR: begin
        mac_clear = 1'b1;
        state_d   = acc_mode_q ? RD_C : RD_A;
        if (col_q == n_q - IDX_W'(1)) begin
          col_d = '0;
          if (row_q == m_q - IDX_W'(1)) state_d = FIN;
          else                          row_d   = row_q + IDX_W'(1);
        end else begin
          col_d = col_q + IDX_W'(1);
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      DIM0: read_d = 1'b1;
      DIM1: begin read_d = 1'b1; i_d = IDX_W'(1); end
      DIM2: begin read_d = 1'b1; i_d = IDX_W'(2); end
      RD_C: begin read_d = 1'b1; sel_d = SEL_C; i_d = row_d; j_d = col_d; end
      RD_A: begin read_d = 1'b1; sel_d = SEL_A; i_d = row_d; j_d = kk_d;  end
      RD_B: begin read_d = 1'b1; sel_d = SEL_B; i_d = kk_d;  j_d = col_d; end
      WR:   begin write_d = 1'b1; sel_d = SEL_C; i_d = row_d; j_d = col_d; end
      FIN:  begin done_d = 1'b1; busy_d = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      kk_q       <= '0;
      acc_mode_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_dim    <= 1'b0;
      i          <= '0;
      j          <= '0;
      sel        <= SEL_DIM;
      read       <= 1'b0;
      write      <= 1'b0;
      write_data <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      k_q        <= k_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kk_q       <= kk_d;
      acc_mode_q <= acc_mode_d;
      busy       <= busy_d;
      done       <= done_d;
      err_dim    <= err_d;
      i          <= i_d;
      j          <= j_d;
      sel        <= sel_d;
      read       <= read_d;
      write      <= write_d;
      write_data <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mm_engine_param.sv
module tb_mm_engine_param;

  localparam int unsigned DW = 20;
  localparam int unsigned IW = 20;
  localparam int unsigned OW = 40;
  localparam int unsigned SW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, acc_mode;
  logic          busy, done, err_dim, read, write;
  logic [IW-1:0] i, j;
  logic [1:0]    sel;
  logic [DW-1:0] read_data;
  logic [OW-1:0] write_data;

  logic          start_s;
  logic          busy_s, done_s, err_s, read_s, write_s;
  logic [IW-1:0] i_s, j_s;
  logic [1:0]    sel_s;
  logic [DW-1:0] rd_s;
  logic [SW-1:0] wd_s;

  mm_engine_param dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
    .busy(busy), .done(done), .err_dim(err_dim), .i(i), .j(j), .sel(sel),
    .read(read), .write(write), .read_data(read_data), .write_data(write_data)
  );

  mm_engine_param #(.DATA_W(DW), .IDX_W(IW), .OUT_W(SW), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start_s), .acc_mode(1'b0),
    .busy(busy_s), .done(done_s), .err_dim(err_s), .i(i_s), .j(j_s), .sel(sel_s),
    .read(read_s), .write(write_s), .read_data(rd_s), .write_data(wd_s)
  );

  // RAM model for the main instance
  logic signed [DW-1:0] mem_a [4][4];
  logic signed [DW-1:0] mem_b [4][4];
  logic signed [DW-1:0] mem_c [4][4];
  logic        [DW-1:0] dims  [3];

  always_comb begin
    read_data = '0;
    if (i < 4 && j < 4) begin
      case (sel)
        2'b00:   if (i < 3) read_data = dims[i[1:0]];
        2'b01:   read_data = mem_a[i[1:0]][j[1:0]];
        2'b10:   read_data = mem_b[i[1:0]][j[1:0]];
        default: read_data = mem_c[i[1:0]][j[1:0]];
      endcase
    end
  end

  // RAM model for the saturating instance: 1x4x1, A all most-negative
  logic [DW-1:0] dims_s [3];
  logic [DW-1:0] sat_b;
  always_comb begin
    rd_s = '0;
    case (sel_s)
      2'b00:   if (i_s < 3) rd_s = dims_s[i_s[1:0]];
      2'b01:   rd_s = 20'h80000;
      2'b10:   rd_s = sat_b;
      default: rd_s = '0;
    endcase
  end

  typedef struct {
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic [OW-1:0] v;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected C writes, straight from the matrix definition.
  task automatic model_fill(input int m, input int k, input int n, input bit am);
    longint s;
    wr_t    e;
    if (m == 0 || k == 0 || n == 0) return;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        s = am ? longint'(mem_c[r][c]) : 64'sd0;
        for (int x = 0; x < k; x++) s += longint'(mem_a[r][x]) * longint'(mem_b[x][c]);
        e.r = IW'(r);
        e.c = IW'(c);
        e.v = s[OW-1:0];
        exp_q.push_back(e);
      end
  endtask

  task automatic push_lit(input int r, input int c, input longint v);
    wr_t e;
    e.r = IW'(r);
    e.c = IW'(c);
    e.v = v[OW-1:0];
    exp_q.push_back(e);
  endtask

  // Compare process: every write must match the next expected element.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rw_excl", 64'(read & write), 64'd0);
      if (write) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got write at (%0d,%0d) expected none", i, j);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'({i, j}), 64'({e.r, e.c}));
          chk("wr_sel", 64'(sel), 64'd3);
          chk("wr_data", 64'(write_data), 64'(e.v));
        end
      end
    end
  end

  task automatic set_dims(input int m, input int k, input int n);
    dims[0] = DW'(m);
    dims[1] = DW'(k);
    dims[2] = DW'(n);
  endtask

  task automatic run_job(input int m, input int k, input int n, input bit am, input bit hold);
    int  lat, cnt;
    bit  got, zero;
    zero = (m == 0 || k == 0 || n == 0);
    lat  = zero ? 4 : 3 + m * n * (2 * k + 1 + int'(am)) + 1;
    set_dims(m, k, n);
    @(negedge clk);
    start    = 1'b1;
    acc_mode = am;
    cnt = 0;
    got = 1'b0;
    while (cnt < 2000 && !got) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (!hold) start = 1'b0;
      acc_mode = 1'($urandom);
      if (cnt == 1) begin
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_cleared", 64'(err_dim), 64'd0);
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
      return;
    end
    chk("latency", 64'(cnt), 64'(lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("err_dim", 64'(err_dim), 64'(zero));
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("err_held", 64'(err_dim), 64'(zero));
    exp_q.delete();
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem_a[r][c] = DW'($urandom);
        mem_b[r][c] = DW'($urandom);
        mem_c[r][c] = DW'($urandom);
      end
  endtask

  task automatic run_sat(input logic [DW-1:0] bval, input logic [SW-1:0] expv);
    int cnt;
    bit got_w, got_d;
    sat_b = bval;
    @(negedge clk);
    start_s = 1'b1;
    cnt = 0;
    got_w = 1'b0;
    got_d = 1'b0;
    while (cnt < 100 && !got_d) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      start_s = 1'b0;
      if (write_s) begin
        got_w = 1'b1;
        chk("sat_data", 64'(wd_s), 64'(expv));
      end
      if (done_s) got_d = 1'b1;
    end
    chk("sat_write_seen", 64'(got_w), 64'd1);
    chk("sat_latency", 64'(cnt), 64'd13);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint neg;
    reset    = 1'b1;
    start    = 1'b0;
    start_s  = 1'b0;
    acc_mode = 1'b0;
    sat_b    = '0;
    dims_s[0] = 20'd1;
    dims_s[1] = 20'd4;
    dims_s[2] = 20'd1;
    rand_mats();
    set_dims(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, err_dim, read, write, sel, i[7:0], j[7:0]}), 64'd0);
    chk("reset_wdata", 64'(write_data), 64'd0);
    reset = 1'b0;

    // 2x2x2 literal case
    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
    model_fill(2, 2, 2, 1'b0);
    chk("model_pin_c00", 64'(exp_q[0].v), 64'd19);
    chk("model_pin_c11", 64'(exp_q[3].v), 64'd50);
    exp_q.delete();
    push_lit(0, 0, 19); push_lit(0, 1, 22); push_lit(1, 0, 43); push_lit(1, 1, 50);
    run_job(2, 2, 2, 1'b0, 1'b0);

    // signed 1x1x1
    mem_a[0][0] = -3;
    mem_b[0][0] = 20'sh7FFFF;
    neg = -1572861;
    push_lit(0, 0, neg);
    run_job(1, 1, 1, 1'b0, 1'b0);

    // accumulate 1x2x1
    mem_c[0][0] = 100;
    mem_a[0][0] = 2; mem_a[0][1] = 3;
    mem_b[0][0] = 4; mem_b[1][0] = 5;
    push_lit(0, 0, 123);
    run_job(1, 2, 1, 1'b1, 1'b0);

    // zero dimension: no writes, err_dim held, cleared by next start
    run_job(2, 0, 3, 1'b0, 1'b0);
    run_job(3, 2, 0, 1'b1, 1'b0);

    // reset in the middle of RD_B of a 3x3x3 job
    rand_mats();
    set_dims(3, 3, 3);
    @(negedge clk);
    start = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_sel_b", 64'(sel), 64'd2);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midjob_reset_out", 64'({busy, done, err_dim, read, write, sel, i[7:0], j[7:0]}), 64'd0);
    chk("midjob_reset_wdata", 64'(write_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_fill(3, 3, 3, 1'b1);
    run_job(3, 3, 3, 1'b1, 1'b1);

    // randomized jobs, including extreme operands
    for (int t = 0; t < 8; t++) begin
      int m, k, n;
      bit am;
      rand_mats();
      if (t % 3 == 0) begin
        mem_a[0][0] = 20'sh80000;
        mem_b[0][0] = 20'sh80000;
      end
      m  = int'($urandom_range(1, 3));
      k  = int'($urandom_range(1, 4));
      n  = int'($urandom_range(1, 3));
      am = 1'($urandom);
      model_fill(m, k, n, am);
      run_job(m, k, n, am, 1'($urandom));
    end

    // saturation: positive and negative clamps
    run_sat(20'h80000, 24'h7FFFFF);
    run_sat(20'h7FFFF, 24'h800000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
